// File: rtl/mac_unit_param.sv
`default_nettype none
// ============================================================================
// Module   : mac_unit_param
// Purpose  : Signed multiply-accumulate lane with bias, ReLU, shift and
//            saturation, using valid/ready handshakes on taps, bias and result.
// Options  : MAC_ROUND_EN - round-half-up on the output shift (default: truncate)
// Revision : 1.0 - initial parametrised release
// ============================================================================
module mac_unit_param #(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 48,
    parameter int SHIFT_W = 6
) (
    input  logic               clk,
    input  logic               rst_pe,
    input  logic               start,
    input  logic [SHIFT_W-1:0] cfg_bias_shift,
    input  logic [SHIFT_W-1:0] cfg_out_shift,
    input  logic               cfg_relu_en,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_feature,
    input  logic [DATA_W-1:0]  in_weight,
    input  logic               in_last,
    input  logic               bias_valid,
    output logic               bias_ready,
    input  logic [DATA_W-1:0]  bias,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_feature,
    output logic               out_sat,
    output logic               busy
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_BIAS  = 3'd2,
        ST_ACT   = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [31:0] c_bs_max = 32'(ACC_W - DATA_W);
    localparam logic [31:0] c_os_max = 32'(ACC_W - 1);
    localparam logic signed [ACC_W:0] c_max = {{(ACC_W-DATA_W+2){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_min = {{(ACC_W-DATA_W+2){1'b1}}, {(DATA_W-1){1'b0}}};

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic signed [ACC_W-1:0]   r_acc;
    logic [SHIFT_W-1:0]        r_bias_shift;
    logic [SHIFT_W-1:0]        r_out_shift;
    logic                      r_relu_en;
    logic                      r_out_valid;
    logic [DATA_W-1:0]         r_out_feature;
    logic                      r_out_sat;

    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;
    logic signed [ACC_W-1:0]    w_bias_ext;
    logic signed [ACC_W-1:0]    w_bias_sh;
    logic [31:0]                w_bs;
    logic [31:0]                w_os;
    logic signed [ACC_W-1:0]    w_act_acc;
    logic signed [ACC_W:0]      w_rnd_add;
    logic signed [ACC_W:0]      w_rnd_in;
    logic signed [ACC_W:0]      w_shifted;
    logic                       w_sat_hi;
    logic                       w_sat_lo;
    logic [DATA_W-1:0]          w_out_val;

    assign w_prod     = $signed(in_feature) * $signed(in_weight);
    assign w_prod_ext = {{(ACC_W-2*DATA_W){w_prod[2*DATA_W-1]}}, w_prod};
    assign w_bias_ext = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};

    assign w_bs      = (32'(r_bias_shift) > c_bs_max) ? c_bs_max : 32'(r_bias_shift);
    assign w_os      = (32'(r_out_shift) > c_os_max) ? c_os_max : 32'(r_out_shift);
    assign w_bias_sh = w_bias_ext <<< w_bs;

    // ReLU keys off the real accumulator MSB so wide positive sums survive
    assign w_act_acc = (r_relu_en && r_acc[ACC_W-1]) ? '0 : r_acc;

`ifdef MAC_ROUND_EN
    assign w_rnd_add = (w_os != 32'd0) ? ({{ACC_W{1'b0}}, 1'b1} << (w_os - 32'd1)) : '0;
`else
    assign w_rnd_add = '0;
`endif

    // One guard bit keeps the rounding add from wrapping before saturation
    assign w_rnd_in  = {w_act_acc[ACC_W-1], w_act_acc} + w_rnd_add;
    assign w_shifted = w_rnd_in >>> w_os;
    assign w_sat_hi  = (w_shifted > c_max);
    assign w_sat_lo  = (w_shifted < c_min);
    assign w_out_val = w_sat_hi ? c_max[DATA_W-1:0] :
                       w_sat_lo ? c_min[DATA_W-1:0] : w_shifted[DATA_W-1:0];

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (start)                w_state_nxt = ST_ACCUM;
            ST_ACCUM: if (in_valid && in_last)  w_state_nxt = ST_BIAS;
            ST_BIAS:  if (bias_valid)           w_state_nxt = ST_ACT;
            ST_ACT:                             w_state_nxt = ST_OUT;
            ST_OUT:   if (out_ready)            w_state_nxt = ST_IDLE;
            default:                            w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_pe) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_bias_shift  <= '0;
            r_out_shift   <= '0;
            r_relu_en     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_feature <= '0;
            r_out_sat     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_bias_shift <= cfg_bias_shift;
                        r_out_shift  <= cfg_out_shift;
                        r_relu_en    <= cfg_relu_en;
                        r_acc        <= '0;
                    end
                end
                ST_ACCUM: if (in_valid)   r_acc <= r_acc + w_prod_ext;
                ST_BIAS:  if (bias_valid) r_acc <= r_acc + w_bias_sh;
                ST_ACT: begin
                    r_acc         <= w_act_acc;
                    r_out_feature <= w_out_val;
                    r_out_sat     <= w_sat_hi | w_sat_lo;
                    r_out_valid   <= 1'b1;
                end
                ST_OUT:   if (out_ready)  r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign in_ready    = (r_state == ST_ACCUM);
    assign bias_ready  = (r_state == ST_BIAS);
    assign busy        = (r_state != ST_IDLE);
    assign out_valid   = r_out_valid;
    assign out_feature = r_out_feature;
    assign out_sat     = r_out_sat;

endmodule
`default_nettype wire
